// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bus: per-requester valid/addr/data, the one-hot grant
// back to the requesters, and the pipeline-freeze hold.
interface rf_wb_arbiter_if #(
  parameter int k    = 32,
  parameter int NREQ = 2
) ();
  // Handshake: a requester's transfer happens on the clock edge where
  // req_valid[i] & req_ready[i] is 1. req_ready may follow req_valid
  // combinationally; req_valid must never depend on req_ready. Once
  // req_valid[i] rises, its addr/data stay stable and valid stays high
  // until that transfer edge.
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [k*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wb_hold;

  modport master (
    output req_valid, req_addr, req_data, wb_hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, wb_hold,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter of NREQ writeback sources onto the register file write
// port, with a registered write stage, x0 filtering and a contention counter.
module rf_wb_arbiter #(
  parameter int k    = 32,
  parameter int NREQ = 2,
  parameter int CW   = 16,
  localparam int PW  = (NREQ > 2) ? 2 : 1
) (
  input  logic                clk,
  input  logic                rst,
  rf_wb_arbiter_if.slave      bus,
  output logic                write_enable,
  output logic [4:0]          Rd_Address,
  output logic [k-1:0]        Rd,
  output logic [31:0]         pending_mask,
  output logic [CW-1:0]       contention_cnt,
  output logic [PW-1:0]       dbg_ptr
);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   sel_idx;
  logic [4:0]      sel_addr;
  logic [k-1:0]    sel_data;
  logic [2:0]      nvalid;
  logic            multi;
  int              j;

  // Scan ptr, ptr+1, ... (mod NREQ); reset and hold both suppress any grant.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    j        = 0;
    if (rst && !bus.wb_hold) begin
      for (int i = 0; i < NREQ; i++) begin
        j = int'(ptr) + i;
        if (j >= NREQ) j = j - NREQ;
        if (!found && bus.req_valid[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          sel_idx  = PW'(j);
          sel_addr = bus.req_addr[j*5 +: 5];
          sel_data = bus.req_data[j*k +: k];
        end
      end
    end
  end

  assign bus.req_ready = grant;

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      nvalid = nvalid + 3'(bus.req_valid[i]);
    end
  end

  assign multi = (nvalid >= 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr            <= '0;
      write_enable   <= 1'b0;
      Rd_Address     <= '0;
      Rd             <= '0;
      contention_cnt <= '0;
    end else begin
      if (found) begin
        ptr <= (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
        // An x0 transfer is consumed but never reaches the register file.
        if (sel_addr != 5'd0) begin
          write_enable <= 1'b1;
          Rd_Address   <= sel_addr;
          Rd           <= sel_data;
        end else begin
          write_enable <= 1'b0;
          Rd_Address   <= '0;
          Rd           <= '0;
        end
      end else begin
        write_enable <= 1'b0;
      end
      if (multi && (contention_cnt != {CW{1'b1}})) begin
        contention_cnt <= contention_cnt + CW'(1);
      end
    end
  end

  assign pending_mask = write_enable ? (32'd1 << Rd_Address) : 32'd0;
  assign dbg_ptr      = ptr;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates NREQ writeback sources onto the single write port of the 32-entry register file. Arbitration is round-robin with a valid/ready handshake. The write is registered, and writes addressed to x0 are filtered out. Sits between the execute/load writeback stages and the register file write port (write_enable, Rd_Address, Rd). It also exports an in-flight mask for hazard/bypass logic and a saturating contention counter.

Parameters:
k, 32, data width of register file entries and writeback data
NREQ, 2, number of writeback requesters (2..4)
CW, 16, width of contention counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
wb_hold  input  1  1 = grant nothing this cycle (pipeline freeze)
req_valid  input  NREQ  per-requester write request
req_addr  input  5*NREQ  destination register, requester i at [5i+4:5i]
req_data  input  k*NREQ  write data, requester i at [ki+k-1:ki]
req_ready  output  NREQ  one-hot grant; transfer when valid&ready
write_enable  output  1  registered RF write strobe
Rd_Address  output  5  registered RF write address
Rd  output  k  registered RF write data
pending_mask  output  32  bit r = 1 when register r is being written this cycle (one-hot or zero)
contention_cnt  output  CW  saturating count of cycles with >1 valid requester

Behaviour:
- Reset (rst low, asynchronous, no clock needed): write_enable=0, Rd_Address=0, Rd=0, pending_mask=0, contention_cnt=0, round-robin pointer ptr=0. req_ready forced to all-zero while rst is low.
- Grant, combinational:
  - If wb_hold=1 or no req_valid set: req_ready=0.
  - Otherwise req_ready is one-hot on the first valid requester found scanning ptr, ptr+1, … mod NREQ.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Requester rule: once req_valid is asserted, req_addr and req_data stay stable and req_valid stays high until the transfer cycle.
- Pointer update at clock edge:
  - Transfer on requester g → ptr <= (g+1) mod NREQ.
  - No transfer → ptr unchanged.
  - Guarantees every valid requester is granted within NREQ transfer cycles (no starvation).
- Output stage, registered; latency 1 cycle from transfer edge to write strobe:
  - On transfer from g with addr≠0: write_enable<=1, Rd_Address<=addr_g, Rd<=data_g. The RF captures it on the following edge.
  - On transfer with addr=0: the handshake completes (request consumed). write_enable<=0, Rd_Address<=0, Rd<=0. The x0 write is dropped.
  - No transfer: write_enable<=0. Rd_Address and Rd hold their previous values (don't-care to RF).
- pending_mask = write_enable ? (1<<Rd_Address) : 0. It is combinational from the output registers and never has bit 0 set.
- Contention counter:
  - Increments at an edge when popcount(req_valid)≥2, regardless of wb_hold.
  - Saturates at 2^CW-1; it does not wrap.
- Simultaneous same address from two requesters: served in round-robin order on consecutive cycles, so the RF ends with the later-granted data. No merging.
- Back-to-back: one transfer per cycle sustained. write_enable may stay high on consecutive cycles.
- wb_hold asserted while write_enable=1: the already-registered write still completes. Only new grants are blocked.
- Reset mid-operation: an in-flight registered write is discarded (write_enable drops immediately). Pending requests are not granted until rst releases. ptr restarts at 0.

Test Plan:
- Reset release, NREQ=2, req0 valid addr=5 data=0xDEADBEEF → req_ready=01 same cycle; next cycle write_enable=1, Rd_Address=5, Rd=0xDEADBEEF, pending_mask=0x00000020.
- Both valid continuously (req0 addr=3 data=0x11, req1 addr=4 data=0x22), requests re-presented after each grant → grants alternate 01,10,01,10…. write_enable high every cycle from cycle 1. contention_cnt increments by 1 per cycle.
- req1 valid addr=0 data=0xFFFF → req_ready=10 and handshake completes. Next cycle write_enable=0, pending_mask=0, Rd_Address=0. ptr advances to 0.
- Both valid, both addr=7, data 0xA then 0xB, ptr=0 → writes to x7 appear with 0xA then 0xB on consecutive cycles. RF x7 ends as 0xB.
- wb_hold=1 for 3 cycles with req0 valid → req_ready=0 and write_enable=0 for those cycles. Grant occurs the first cycle wb_hold=0.
- Assert rst low mid-stream while write_enable=1 → write_enable, Rd_Address, Rd, pending_mask go 0 immediately (before next clk edge). With CW=2 and 5 contention cycles, contention_cnt stops at 3.
